// File: rtl/pwm_4096step_gen_pkg.sv
// Shared constants, FSM state type and duty clamp for the 4096-step PWM generator.
// The optional dead-time stage is enabled in the top with PWM_DEADTIME_EN.
package pwm_pkg;

    localparam int unsigned CNT_W     = 12;
    localparam int unsigned PWM_STEPS = 2 ** CNT_W;
    localparam int unsigned PRESC_W   = 16;

    typedef enum logic {
        IDLE,
        RUN
    } pwm_state_t;

    // Duty register is 13 bits wide; anything above a full period means "always on".
    function automatic logic [CNT_W:0] sat_duty(input logic [CNT_W:0] duty);
        logic [CNT_W:0] steps;
        steps = (CNT_W + 1)'(PWM_STEPS);
        return (duty > steps) ? steps : duty;
    endfunction

endpackage

// File: rtl/pwm_4096step_gen_prescaler.sv
// Clock prescaler: one tick every prescale_i+1 clocks, held at zero while clear_i is set.
module pwm_prescaler #(
    parameter int unsigned PRESC_W = pwm_pkg::PRESC_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic [PRESC_W-1:0] prescale_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] presc_cnt_q;
    logic [PRESC_W-1:0] presc_cnt_d;

    // A prescale value lowered below the count simply lets the counter wrap around.
    always_comb begin
        tick_o      = 1'b0;
        presc_cnt_d = presc_cnt_q + 1'b1;
        if (clear_i) begin
            presc_cnt_d = '0;
        end else if (presc_cnt_q == prescale_i) begin
            tick_o      = 1'b1;
            presc_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_4096step_gen.sv
// 4096-step PWM generator with period-boundary duty shadowing.
// Define PWM_DEADTIME_EN to add dead-time insertion on the complementary outputs.
module pwm_4096step_gen #(
    parameter int unsigned CNT_W   = pwm_pkg::CNT_W,
    parameter int unsigned PRESC_W = pwm_pkg::PRESC_W,
    parameter int unsigned DT_W    = 8
) (
    input  logic               s00_axi_aclk,
    input  logic               s00_axi_aresetn,
    input  logic               cfg_enable,
    input  logic               cfg_polarity,
    input  logic [PRESC_W-1:0] cfg_prescale,
    input  logic [CNT_W:0]     cfg_duty,
    input  logic [DT_W-1:0]    cfg_deadtime,
    output logic               pwm_out,
    output logic               pwm_out_n,
    output logic               period_done,
    output logic [CNT_W-1:0]   cnt_value
);
    import pwm_pkg::*;

    pwm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   duty_sh_q, duty_sh_d;
    logic             done_q, done_d;
    logic             pwm_q, pwm_d;
    logic             pwm_n_q, pwm_n_d;
    logic             tick;
    logic             presc_clear;
    logic             run_next;
    logic             phase;

    assign run_next    = (state_q == RUN) && cfg_enable;
    assign presc_clear = !run_next;
    assign phase       = ({1'b0, cnt_q} < duty_sh_q) ^ cfg_polarity;

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk_i      (s00_axi_aclk),
        .rst_ni     (s00_axi_aresetn),
        .clear_i    (presc_clear),
        .prescale_i (cfg_prescale),
        .tick_o     (tick)
    );

    // Disable takes priority over a coincident wrap: no pulse, no shadow load.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        duty_sh_d = duty_sh_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cfg_enable) begin
                    state_d   = RUN;
                    duty_sh_d = sat_duty(cfg_duty);
                end
            end
            RUN: begin
                if (!cfg_enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        done_d    = 1'b1;
                        duty_sh_d = sat_duty(cfg_duty);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PWM_DEADTIME_EN
    logic            phase_q;
    logic [DT_W-1:0] dt_q, dt_d;
    logic            dt_ok;

    // dt counts clocks since the phase last flipped; the rising side waits for it.
    always_comb begin
        dt_d    = (phase != phase_q) ? '0 : ((&dt_q) ? dt_q : dt_q + 1'b1);
        dt_ok   = (dt_d >= cfg_deadtime);
        pwm_d   = cfg_polarity;
        pwm_n_d = cfg_polarity;
        if (run_next) begin
            pwm_d   = phase & dt_ok;
            pwm_n_d = ~phase & dt_ok;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            phase_q <= 1'b0;
            dt_q    <= '0;
        end else begin
            phase_q <= run_next ? phase : 1'b0;
            dt_q    <= run_next ? dt_d : '0;
        end
    end
`else
    logic unused_deadtime;
    assign unused_deadtime = ^cfg_deadtime;

    always_comb begin
        pwm_d   = cfg_polarity;
        pwm_n_d = cfg_polarity;
        if (run_next) begin
            pwm_d   = phase;
            pwm_n_d = ~phase;
        end
    end
`endif

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            duty_sh_q <= '0;
            done_q    <= 1'b0;
            pwm_q     <= 1'b0;
            pwm_n_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            duty_sh_q <= duty_sh_d;
            done_q    <= done_d;
            pwm_q     <= pwm_d;
            pwm_n_q   <= pwm_n_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign pwm_out_n   = pwm_n_q;
    assign period_done = done_q;
    assign cnt_value   = cnt_q;

endmodule

// File: tb/tb_pwm_4096step_gen.sv
// Self-checking bench for pwm_4096step_gen; extra dead-time checks when PWM_DEADTIME_EN is defined.
module tb_pwm_4096step_gen;

    localparam int STEPS = 4096;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        pol   = 1'b1;
    logic [15:0] presc = '0;
    logic [12:0] duty  = '0;
    logic [7:0]  dt    = '0;
    logic        pwm, pwm_n, done;
    logic [11:0] cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_4096step_gen dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .cfg_enable      (en),
        .cfg_polarity    (pol),
        .cfg_prescale    (presc),
        .cfg_duty        (duty),
        .cfg_deadtime    (dt),
        .pwm_out         (pwm),
        .pwm_out_n       (pwm_n),
        .period_done     (done),
        .cnt_value       (cnt)
    );

    typedef struct {
        int p;
        int duty;
        bit pol;
        int exp_hi;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic report(input string name, input int bad, input int k, input int got, input int exp);
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL %s: %0d bad cycles (first at k=%0d got %0d want %0d), required 0",
                     name, bad, k, got, exp);
        end
    endtask

    function automatic int sat(input int d);
        return (d > STEPS) ? STEPS : d;
    endfunction

    // Enable at edge E0 with duty d0; duty becomes d1 before edge jc. Sample after E0..En.
    // Expected values come from closed-form arithmetic on the edge index k.
    task automatic run_check(input int p, input int d0, input int d1, input int jc,
                             input bit pl, input int n, output int hi0, output int hi1);
        int L, e_cnt, e_done, e_pwm, e_n, c, m, d;
        int b_cnt = 0, b_done = 0, b_pwm = 0, b_n = 0;
        int k_cnt = 0, k_done = 0, k_pwm = 0, k_n = 0;
        int g_cnt = 0, g_done = 0, g_pwm = 0, g_n = 0;
        int x_cnt = 0, x_done = 0, x_pwm = 0, x_n = 0;
        L = STEPS * (p + 1);
        hi0 = 0;
        hi1 = 0;
        @(negedge clk);
        en = 1'b0;
        dt = '0;
        @(negedge clk);
        presc = 16'(p);
        duty  = 13'(d0);
        pol   = pl;
        en    = 1'b1;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            e_cnt  = (k / (p + 1)) % STEPS;
            e_done = (k > 0 && (k % L) == 0) ? 1 : 0;
            if (k == 0) begin
                e_pwm = int'(pl);
                e_n   = int'(pl);
            end else begin
                c     = ((k - 1) / (p + 1)) % STEPS;
                m     = (k - 1) / L;
                d     = sat((m * L >= jc) ? d1 : d0);
                e_pwm = ((c < d) ? 1 : 0) ^ int'(pl);
                e_n   = 1 - e_pwm;
            end
            if (int'(cnt) != e_cnt) begin
                if (b_cnt == 0) begin k_cnt = k; g_cnt = int'(cnt); x_cnt = e_cnt; end
                b_cnt++;
            end
            if (int'(done) != e_done) begin
                if (b_done == 0) begin k_done = k; g_done = int'(done); x_done = e_done; end
                b_done++;
            end
            if (int'(pwm) != e_pwm) begin
                if (b_pwm == 0) begin k_pwm = k; g_pwm = int'(pwm); x_pwm = e_pwm; end
                b_pwm++;
            end
            if (int'(pwm_n) != e_n) begin
                if (b_n == 0) begin k_n = k; g_n = int'(pwm_n); x_n = e_n; end
                b_n++;
            end
            if (k >= 1 && k <= L) hi0 += int'(pwm);
            else if (k > L && k <= 2 * L) hi1 += int'(pwm);
            if (k == jc - 1) duty = 13'(d1);
        end
        report("cnt_value trace", b_cnt, k_cnt, g_cnt, x_cnt);
        report("period_done trace", b_done, k_done, g_done, x_done);
        report("pwm_out trace", b_pwm, k_pwm, g_pwm, x_pwm);
        report("pwm_out_n trace", b_n, k_n, g_n, x_n);
    endtask

    initial begin
        vec_t tbl[5];
        int hi0, hi1, p, d0, d1, pl, L, jc, n;
        tbl[0] = '{0, 1024, 1'b0, 1024};
        tbl[1] = '{0, 0,    1'b0, 0};
        tbl[2] = '{0, 4096, 1'b0, 4096};
        tbl[3] = '{0, 5000, 1'b0, 4096};
        tbl[4] = '{0, 1,    1'b1, 4095};

        // Reset held 200 ns, then released with enable low and polarity high.
        #100;
        check("reset pwm_out", int'(pwm), 0);
        check("reset pwm_out_n", int'(pwm_n), 0);
        check("reset period_done", int'(done), 0);
        check("reset cnt_value", int'(cnt), 0);
        #100;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle pwm_out pol1", int'(pwm), 1);
        check("idle pwm_out_n pol1", int'(pwm_n), 1);
        check("idle cnt_value", int'(cnt), 0);
        check("idle period_done", int'(done), 0);
        pol = 1'b0;
        @(negedge clk);
        check("idle pwm_out pol0", int'(pwm), 0);

        for (int i = 0; i < 5; i++) begin
            run_check(tbl[i].p, tbl[i].duty, tbl[i].duty, STEPS * (tbl[i].p + 1) + 10,
                      tbl[i].pol, STEPS * (tbl[i].p + 1), hi0, hi1);
            check($sformatf("table row %0d high clocks", i), hi0, tbl[i].exp_hi);
        end

        // Duty rewritten to 2048 while cnt is 100: applies from the next period only.
        run_check(0, 1024, 2048, 101, 1'b0, 2 * STEPS, hi0, hi1);
        check("shadow current period high", hi0, 1024);
        check("shadow next period high", hi1, 2048);

        // prescale=3, duty=2, then disable on the wrap tick.
        run_check(3, 2, 2, 1 << 20, 1'b0, 4 * STEPS - 1, hi0, hi1);
        check("prescale3 high clocks", hi0, 8);
        check("pre-wrap cnt_value", int'(cnt), 4095);
        en = 1'b0;
        @(negedge clk);
        check("disable at wrap period_done", int'(done), 0);
        check("disable at wrap cnt_value", int'(cnt), 0);
        check("disable at wrap pwm_out", int'(pwm), 0);
        check("disable at wrap pwm_out_n", int'(pwm_n), 0);
        @(negedge clk);
        check("disable at wrap period_done+1", int'(done), 0);

        for (int r = 0; r < 3; r++) begin
            p  = int'($urandom_range(0, 1));
            d0 = int'($urandom_range(0, 5000));
            d1 = int'($urandom_range(0, 8191));
            pl = int'($urandom_range(0, 1));
            L  = STEPS * (p + 1);
            jc = int'($urandom_range(1, L));
            n  = L + int'($urandom_range(1, 500));
            run_check(p, d0, d1, jc, pl[0], n, hi0, hi1);
        end

`ifdef PWM_DEADTIME_EN
        begin
            int both_low = 0, ph = 0, pn = 0;
            @(negedge clk);
            en = 1'b0;
            @(negedge clk);
            presc = '0;
            duty  = 13'd2048;
            pol   = 1'b0;
            dt    = 8'd5;
            en    = 1'b1;
            @(negedge clk);
            for (int k = 1; k <= STEPS; k++) begin
                @(negedge clk);
                if (!pwm && !pwm_n) both_low++;
                ph += int'(pwm);
                pn += int'(pwm_n);
            end
            check("deadtime both-low clocks", both_low, 10);
            check("deadtime pwm_out high", ph, 2043);
            check("deadtime pwm_out_n high", pn, 2043);
            en = 1'b0;
            @(negedge clk);
            dt = '0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

`ifdef PWM_DEADTIME_EN
    always @(negedge clk) begin
        if (rst_n && en && dt != 0)
            assert (!(pwm && pwm_n)) else $error("FAIL overlap: pwm_out and pwm_out_n both high");
    end
`endif

endmodule
